// File: rtl/asic_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : asic_sample_sequencer
// Purpose  : Walks a block of input samples through asic_function_interface.
//            Each sample is read from the input RAM (1-cycle latency), held
//            on o_asic_data_in, and issued with a start pulse once the
//            interface reports idle. Completion is detected as valid going
//            low and then high again. The result is written to the output
//            RAM at the same index.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_run, i_abort      start pulse (ignored while busy) / abort of active run
//   i_num_samples       sample count, latched when a run is accepted
//   o_busy, o_done      not-idle / sticky completion flag
//   o_timeout_err       sticky per-sample timeout flag
//   o_sample_idx        current sample index
//   o_in_rd_*           input RAM read port (data returns next cycle)
//   o_asic_start        start pulse to the interface
//   o_asic_data_in      registered sample presented to the interface
//   i_asic_data_valid   interface valid (high only when interface is idle)
//   i_asic_data_out     interface result word
//   o_out_wr_*          output RAM write port
// ============================================================================
module asic_sample_sequencer #(
  parameter int ADDR_WIDTH     = 15,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_run,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH:0]   i_num_samples,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_timeout_err,
  output logic [ADDR_WIDTH-1:0] o_sample_idx,
  output logic                  o_in_rd_en,
  output logic [ADDR_WIDTH-1:0] o_in_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_in_rd_data,
  output logic                  o_asic_start,
  output logic [DATA_WIDTH-1:0] o_asic_data_in,
  input  logic                  i_asic_data_valid,
  input  logic [DATA_WIDTH-1:0] i_asic_data_out,
  output logic                  o_out_wr_en,
  output logic [ADDR_WIDTH-1:0] o_out_wr_addr,
  output logic [DATA_WIDTH-1:0] o_out_wr_data
);

  // Spare headroom bit so the counter cannot wrap back below the limit.
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [TW-1:0] C_TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_LATCH     = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_BUSY = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_WRITE     = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [DATA_WIDTH-1:0] r_data_in;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [TW-1:0]         r_timer;
  logic                  r_done;
  logic                  r_timeout_err;

  logic w_timing;
  logic w_last;
  logic w_accept;
  logic w_latch;
  logic w_capture;
  logic w_advance;
  logic w_finish;
  logic w_timeout;

  // States in which the per-sample timer runs.
  assign w_timing = (r_state == S_ISSUE) || (r_state == S_WAIT_BUSY) ||
                    (r_state == S_WAIT_DONE);
  assign w_last   = ({1'b0, r_idx} == (r_count - 1'b1));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    w_finish    = 1'b0;
    w_timeout   = 1'b0;
    if ((r_state != S_IDLE) && i_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_run) begin
            w_accept = 1'b1;
            if (i_num_samples != '0) w_state_nxt = S_READ;
          end
        end
        S_READ:  w_state_nxt = S_LATCH;
        S_LATCH: begin
          w_latch     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
        // Waiting for valid here guarantees no start goes into an interface
        // left mid-conversion by an earlier abort or timeout.
        S_ISSUE:     if (i_asic_data_valid)  w_state_nxt = S_WAIT_BUSY;
        S_WAIT_BUSY: if (!i_asic_data_valid) w_state_nxt = S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (i_asic_data_valid) begin
            w_capture   = 1'b1;
            w_state_nxt = S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_last) begin
            w_finish    = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_advance   = 1'b1;
            w_state_nxt = S_READ;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
      // A real state change that cycle takes precedence over the timeout.
      if (w_timing && (w_state_nxt == r_state) && (r_timer >= C_TIMER_LAST)) begin
        w_timeout   = 1'b1;
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count       <= '0;
      r_idx         <= '0;
      r_data_in     <= '0;
      r_wr_data     <= '0;
      r_timer       <= '0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_timeout_err <= 1'b0;
        if (i_num_samples == '0) begin
          r_done <= 1'b1;
        end else begin
          r_done  <= 1'b0;
          r_count <= i_num_samples;
          r_idx   <= '0;
        end
      end
      if (w_latch) begin
        r_data_in <= i_in_rd_data;
        r_timer   <= '0;
      end else if (w_timing) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_capture) r_wr_data <= i_asic_data_out;
      if (w_advance) r_idx <= r_idx + 1'b1;
      if (w_finish)  r_done <= 1'b1;
      if (w_timeout) begin
        r_done        <= 1'b1;
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = r_done;
  assign o_timeout_err  = r_timeout_err;
  assign o_sample_idx   = r_idx;
  assign o_in_rd_en     = (r_state == S_READ);
  assign o_in_rd_addr   = r_idx;
  assign o_asic_start   = (r_state == S_ISSUE) && i_asic_data_valid;
  assign o_asic_data_in = r_data_in;
  assign o_out_wr_en    = (r_state == S_WRITE);
  assign o_out_wr_addr  = r_idx;
  assign o_out_wr_data  = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_asic_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_asic_sample_sequencer
// Purpose  : Self-checking bench for asic_sample_sequencer. Provides an input
//            RAM, a behavioural conversion interface (result = sample ^ A5A5)
//            and a write log; expected results come from the RAM contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_asic_sample_sequencer;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          abort = 1'b0;
  logic [AW:0]   num_samples = '0;
  logic          busy, done, terr;
  logic [AW-1:0] sample_idx;
  logic          in_rd_en;
  logic [AW-1:0] in_rd_addr;
  logic [DW-1:0] in_rd_data = '0;
  logic          asic_start;
  logic [DW-1:0] asic_data_in;
  logic          asic_data_valid;
  logic [DW-1:0] asic_data_out;
  logic          out_wr_en;
  logic [AW-1:0] out_wr_addr;
  logic [DW-1:0] out_wr_data;

  asic_sample_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .i_run(run), .i_abort(abort), .i_num_samples(num_samples),
    .o_busy(busy), .o_done(done), .o_timeout_err(terr), .o_sample_idx(sample_idx),
    .o_in_rd_en(in_rd_en), .o_in_rd_addr(in_rd_addr), .i_in_rd_data(in_rd_data),
    .o_asic_start(asic_start), .o_asic_data_in(asic_data_in),
    .i_asic_data_valid(asic_data_valid), .i_asic_data_out(asic_data_out),
    .o_out_wr_en(out_wr_en), .o_out_wr_addr(out_wr_addr), .o_out_wr_data(out_wr_data)
  );

  always #5 clk = ~clk;

  // Input RAM with one-cycle read latency.
  logic [DW-1:0] in_ram [2**AW];
  always @(posedge clk) if (in_rd_en) in_rd_data <= in_ram[in_rd_addr];

  // Behavioural interface: busy from the start edge for if_lat cycles,
  // then reports sample ^ A5A5. if_hang keeps it busy; if_hold masks valid.
  logic          if_busy = 1'b0;
  logic          if_hold = 1'b0;
  logic          if_hang = 1'b0;
  int            if_lat  = 20;
  int            if_cnt  = 0;
  logic [DW-1:0] if_data = '0;
  logic [DW-1:0] if_out  = '0;
  assign asic_data_valid = !if_busy && !if_hold;
  assign asic_data_out   = if_out;
  always @(posedge clk) begin
    if (asic_start && !if_busy) begin
      if_busy <= 1'b1;
      if_data <= asic_data_in;
      if_cnt  <= if_lat;
    end else if (if_busy) begin
      if (if_cnt > 1) if_cnt <= if_cnt - 1;
      else if (!if_hang) begin
        if_busy <= 1'b0;
        if_out  <= if_data ^ 16'hA5A5;
      end
    end
  end

  // Activity counters and output-RAM write log.
  int rd_cnt = 0, st_cnt = 0, wr_cnt = 0;
  logic [AW+DW-1:0] wr_q[$];
  always @(posedge clk) begin
    if (in_rd_en)   rd_cnt <= rd_cnt + 1;
    if (asic_start) st_cnt <= st_cnt + 1;
    if (out_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      wr_q.push_back({out_wr_addr, out_wr_data});
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int base_st  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_run(input int n);
    base_st = st_cnt;
    wr_q.delete();
    num_samples = (AW+1)'(n);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    num_samples = (AW+1)'($urandom);  // must not affect the accepted run
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (busy && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("wait_idle", busy, 0);
  endtask

  task automatic wait_valid(input int bound);
    int k = 0;
    while (!asic_data_valid && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("wait_valid", asic_data_valid, 1);
  endtask

  task automatic wait_starts(input int target, input int bound);
    int k = 0;
    while (st_cnt < target && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("wait_starts", st_cnt, target);
  endtask

  // Reference: output word i is input word i ^ A5A5, written in index order.
  task automatic check_results(input int n);
    chk("n_writes", wr_q.size(), n);
    chk("n_starts", st_cnt - base_st, n);
    for (int i = 0; i < n; i++) begin
      if (i < wr_q.size()) begin
        chk("wr_addr", wr_q[i][AW+DW-1:DW], i % (2**AW));
        chk("wr_data", wr_q[i][DW-1:0], in_ram[i] ^ 16'hA5A5);
      end
    end
    chk("done", done, 1);
    chk("timeout_err", terr, 0);
    chk("busy", busy, 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_terr", terr, 0);
    chk("rst_idx", sample_idx, 0);
    chk("rst_rd_en", in_rd_en, 0);
    chk("rst_start", asic_start, 0);
    chk("rst_wr_en", out_wr_en, 0);
    chk("rst_data_in", asic_data_in, 0);
    chk("rst_wr_data", out_wr_data, 0);
  endtask

  initial begin
    int n;
    int cyc;
    int k;
    for (int i = 0; i < 2**AW; i++) in_ram[i] = DW'(i * 3);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs();

    // Zero-length run: done next cycle, no activity at all.
    do_run(0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("zero_rd", rd_cnt, 0);
    chk("zero_st", st_cnt, 0);
    chk("zero_wr", wr_cnt, 0);

    // Directed 4-sample run, RAM[i] = 3*i, 20-cycle conversions.
    if_lat = 20;
    do_run(4);
    wait_idle(400);
    check_results(4);

    // Randomized runs.
    for (int i = 0; i < 2**AW; i++) in_ram[i] = DW'($urandom);
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 12);
      if_lat = $urandom_range(1, 30);
      do_run(n);
      wait_idle(n * 60 + 20);
      check_results(n);
    end

    // Full-depth run: last index is 2^AW - 1, no wrap.
    if_lat = 1;
    do_run(2**AW);
    wait_idle(2**AW * 20);
    check_results(2**AW);
    chk("full_last_idx", sample_idx, 2**AW - 1);

    // Valid held low before the run: start coincides with valid rising.
    if_hold = 1'b1;
    if_lat  = 10;
    do_run(2);
    repeat (30) @(negedge clk);
    chk("hold_no_start", st_cnt - base_st, 0);
    chk("hold_busy", busy, 1);
    if_hold = 1'b0;
    #1;
    chk("hold_start_on_valid", asic_start, 1);
    wait_idle(200);
    check_results(2);

    // Timeout: interface never completes.
    if_hang = 1'b1;
    if_lat  = 5;
    do_run(3);
    k = 0;
    while (!asic_start && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("to_issue_seen", asic_start, 1);
    cyc = 0;
    while (busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("to_cycles", cyc, TO);
    chk("to_terr", terr, 1);
    chk("to_done", done, 1);
    chk("to_idx", sample_idx, 0);
    chk("to_writes", wr_q.size(), 0);
    if_hang = 1'b0;
    wait_valid(50);

    // Abort in WAIT_DONE of sample index 2 of 5.
    if_lat = 20;
    do_run(5);
    wait_starts(base_st + 3, 300);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_terr", terr, 0);
    chk("abort_writes", wr_q.size(), 2);
    for (int i = 0; i < 2; i++) begin
      if (i < wr_q.size()) begin
        chk("abort_wr_addr", wr_q[i][AW+DW-1:DW], i);
        chk("abort_wr_data", wr_q[i][DW-1:0], in_ram[i] ^ 16'hA5A5);
      end
    end
    repeat (5) @(negedge clk);
    chk("abort_no_late_write", wr_q.size(), 2);
    wait_valid(50);
    do_run(2);
    wait_idle(200);
    check_results(2);

    // Run pulse while busy is ignored; rst in WAIT_BUSY.
    if_lat = 10;
    do_run(4);
    k = 0;
    while (wr_q.size() < 1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("busy_run_first_write", wr_q.size(), 1);
    num_samples = 1;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wait_starts(base_st + 2, 100);
    chk("busy_run_ignored_idx", sample_idx, 1);
    chk("busy_run_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs();
    repeat (40) @(negedge clk);
    chk("post_rst_writes", wr_q.size(), 1);
    chk("post_rst_starts", st_cnt - base_st, 2);
    chk("post_rst_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
